ram_sdp_be: RTL and testbench

//   Simple dual-port synchronous RAM (one write port, one read port) with byte-enable writes,

---
 rtl/ram_sdp_be_if.sv | 26 ++
 rtl/ram_sdp_be.sv | 209 ++++++++++++++++++++
 tb/tb_ram_sdp_be.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sdp_be_if.sv
// Write/read port bundle for the byte-enable simple dual-port RAM.
// The master drives requests; the slave (the RAM) returns read data, the strobe and the sweep flag.
interface ram_sdp_be_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
);
   logic                      we;
   logic [ADDR_WIDTH-1:0]     waddr;
   logic [DATA_WIDTH/8-1:0]   wbe;
   logic [DATA_WIDTH-1:0]     wdata;
   logic                      re;
   logic [ADDR_WIDTH-1:0]     raddr;
   logic [DATA_WIDTH-1:0]     rdata;
   logic                      rvalid;
   logic                      init_busy;

   modport master (
      output we, waddr, wbe, wdata, re, raddr,
      input  rdata, rvalid, init_busy
   );

   modport slave (
      input  we, waddr, wbe, wdata, re, raddr,
      output rdata, rvalid, init_busy
   );
endinterface

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with byte-enable writes, 1- or 2-cycle registered reads,
// selectable read-during-write behaviour and an optional zeroing sweep after reset.
module ram_sdp_be #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 7,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic          clk,
   input  logic          rst,
   ram_sdp_be_if.slave   bus
);
   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

   generate
      if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
         $error("ram_sdp_be: DATA_WIDTH must be a multiple of 8");
      end
      if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
         $error("ram_sdp_be: READ_LATENCY must be 1 or 2");
      end
      if ((RDW_MODE != 0) && (RDW_MODE != 1)) begin : g_bad_rdw_mode
         $error("ram_sdp_be: RDW_MODE must be 0 or 1");
      end
      if ((CLEAR_ON_RESET != 0) && (CLEAR_ON_RESET != 1)) begin : g_bad_clear
         $error("ram_sdp_be: CLEAR_ON_RESET must be 0 or 1");
      end
   endgenerate

   // Enabled bytes from wr_word, remaining bytes from old_word.
   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] wr_word,
      input logic [NBYTES-1:0]     be
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < NBYTES; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = wr_word[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res;
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   state_t                state_r;
   state_t                state_nxt_s;
   logic [ADDR_WIDTH-1:0] clr_idx_r;
   logic                  init_busy_s;
   logic                  clr_en_s;
   logic                  port_en_s;
   logic                  wr_clr_s;
   logic                  wr_acc_s;
   logic                  rd_acc_s;
   logic                  collide_s;
   logic [DATA_WIDTH-1:0] rd_old_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic [DATA_WIDTH-1:0] p1_data_r;
   logic                  p1_valid_r;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= RST_STATE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: the sweep ends after the last word has been zeroed.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_CLEAR: begin
            if (clr_idx_r == LAST_IDX) begin
               state_nxt_s = ST_READY;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         ST_READY: state_nxt_s = ST_READY;
         default:  state_nxt_s = RST_STATE;
      endcase
   end

   // State decode: ports are only serviced in READY.
   always_comb begin
      init_busy_s = 1'b1;
      clr_en_s    = 1'b0;
      port_en_s   = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            init_busy_s = 1'b1;
            clr_en_s    = 1'b1;
            port_en_s   = 1'b0;
         end
         ST_READY: begin
            init_busy_s = 1'b0;
            clr_en_s    = 1'b0;
            port_en_s   = 1'b1;
         end
         default: begin
            init_busy_s = 1'b1;
            clr_en_s    = 1'b0;
            port_en_s   = 1'b0;
         end
      endcase
   end

   assign wr_clr_s = clr_en_s & ~rst;
   assign wr_acc_s = port_en_s & bus.we & ~rst;
   assign rd_acc_s = port_en_s & bus.re & ~rst;

   // Sweep index, restarted by every reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_idx_r <= '0;
      end else if (wr_clr_s) begin
         clr_idx_r <= clr_idx_r + IDX_ONE;
      end else begin
         clr_idx_r <= clr_idx_r;
      end
   end

   // Storage array: per-byte writes keep the write port mappable onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_clr_s) begin
         mem_r[clr_idx_r] <= '0;
      end else if (wr_acc_s) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (bus.wbe[i]) begin
               mem_r[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
         end
      end
   end

   // Read word at the accept edge, forwarding the merged write in write-first mode.
   always_comb begin
      rd_old_s  = mem_r[bus.raddr];
      collide_s = wr_acc_s && (bus.waddr == bus.raddr);
      if ((RDW_MODE != 0) && collide_s) begin
         rd_word_s = merge_bytes(rd_old_s, bus.wdata, bus.wbe);
      end else begin
         rd_word_s = rd_old_s;
      end
   end

   // First read stage: data holds its last value between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         p1_data_r  <= '0;
         p1_valid_r <= 1'b0;
      end else begin
         p1_valid_r <= rd_acc_s;
         if (rd_acc_s) begin
            p1_data_r <= rd_word_s;
         end else begin
            p1_data_r <= p1_data_r;
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] p2_data_r;
         logic                  p2_valid_r;

         // Extra output stage; the collision outcome is already fixed in stage one.
         always_ff @(posedge clk) begin
            if (rst) begin
               p2_data_r  <= '0;
               p2_valid_r <= 1'b0;
            end else begin
               p2_valid_r <= p1_valid_r;
               if (p1_valid_r) begin
                  p2_data_r <= p1_data_r;
               end else begin
                  p2_data_r <= p2_data_r;
               end
            end
         end

         assign bus.rdata  = p2_data_r;
         assign bus.rvalid = p2_valid_r;
      end else begin : g_lat1
         assign bus.rdata  = p1_data_r;
         assign bus.rvalid = p1_valid_r;
      end
   endgenerate

   assign bus.init_busy = init_busy_s;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench: DUT A is read-first with latency 1, DUT B is write-first with latency 2;
// both receive identical stimulus and are checked against hand-computed values.
module tb_ram_sdp_be;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ram_sdp_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) if_a ();
   ram_sdp_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) if_b ();

   ram_sdp_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(7), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
   ) dut_a (
      .clk(clk), .rst(rst), .bus(if_a)
   );

   ram_sdp_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(7), .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
   ) dut_b (
      .clk(clk), .rst(rst), .bus(if_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic we, input logic [6:0] waddr, input logic [3:0] wbe,
                      input logic [31:0] wdata, input logic re, input logic [6:0] raddr);
      if_a.we = we; if_a.waddr = waddr; if_a.wbe = wbe; if_a.wdata = wdata;
      if_a.re = re; if_a.raddr = raddr;
      if_b.we = we; if_b.waddr = waddr; if_b.wbe = wbe; if_b.wdata = wdata;
      if_b.re = re; if_b.raddr = raddr;
   endtask

   task automatic idle();
      drv(1'b0, 7'd0, 4'h0, 32'h0000_0000, 1'b0, 7'd0);
   endtask

   task automatic wr(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] be);
      drv(1'b1, addr, be, data, 1'b0, 7'd0);
      tick();
      idle();
   endtask

   // Single read: A answers one edge after accept, B two edges after.
   task automatic rd(input string tag, input logic [6:0] addr,
                     input logic [31:0] exp_a, input logic [31:0] exp_b);
      drv(1'b0, 7'd0, 4'h0, 32'h0000_0000, 1'b1, addr);
      tick();
      idle();
      check({tag, "_a_rv"}, 32'(if_a.rvalid), 32'd1);
      check({tag, "_a_rd"}, if_a.rdata, exp_a);
      check({tag, "_b_rv0"}, 32'(if_b.rvalid), 32'd0);
      tick();
      check({tag, "_a_rv0"}, 32'(if_a.rvalid), 32'd0);
      check({tag, "_b_rv"}, 32'(if_b.rvalid), 32'd1);
      check({tag, "_b_rd"}, if_b.rdata, exp_b);
   endtask

   // Counts busy cycles after reset release; optionally hammers both ports meanwhile.
   task automatic wait_sweep(input string tag, input int exp_cycles, input bit hold_ports);
      int cnt;
      bit seen_rv;
      cnt = 0;
      seen_rv = 1'b0;
      while ((if_a.init_busy == 1'b1) && (cnt < 1000)) begin
         if (hold_ports) begin
            drv(1'b1, 7'd3, 4'hF, 32'hFFFF_FFFF, 1'b1, 7'd3);
         end
         tick();
         cnt++;
         if (if_a.rvalid || if_b.rvalid) begin
            seen_rv = 1'b1;
         end
      end
      idle();
      check({tag, "_len"}, 32'(cnt), 32'(exp_cycles));
      check({tag, "_b_busy"}, 32'(if_b.init_busy), 32'd0);
      check({tag, "_no_rv"}, 32'(seen_rv), 32'd0);
   endtask

   initial begin
      int cnt;
      bit seen_rv;

      idle();
      rst = 1'b1;
      tick();
      tick();
      check("rst_a_rdata", if_a.rdata, 32'h0000_0000);
      check("rst_a_rvalid", 32'(if_a.rvalid), 32'd0);
      check("rst_a_busy", 32'(if_a.init_busy), 32'd1);
      check("rst_b_rdata", if_b.rdata, 32'h0000_0000);
      check("rst_b_busy", 32'(if_b.init_busy), 32'd1);
      rst = 1'b0;
      wait_sweep("sweep0", 128, 1'b0);

      // 1: fill every word, reset, expect a full 128-cycle sweep back to zero.
      for (int i = 0; i < 128; i++) begin
         wr(7'(i), 32'hA500_0000 | 32'(i), 4'hF);
      end
      rd("t1_pre7", 7'd7, 32'hA500_0007, 32'hA500_0007);
      rd("t1_pre127", 7'd127, 32'hA500_007F, 32'hA500_007F);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_sweep("t1_sweep", 128, 1'b0);
      for (int i = 0; i < 128; i++) begin
         rd($sformatf("t1_rd%0d", i), 7'(i), 32'h0000_0000, 32'h0000_0000);
      end

      // 2: byte-enable merge and an all-disabled write.
      wr(7'd5, 32'hAABB_CCDD, 4'b1111);
      wr(7'd5, 32'h1122_3344, 4'b0101);
      rd("t2_merge", 7'd5, 32'hAA22_CC44, 32'hAA22_CC44);
      wr(7'd6, 32'hFFFF_FFFF, 4'b0000);
      rd("t2_nobe", 7'd6, 32'h0000_0000, 32'h0000_0000);

      // 3: back-to-back reads, latency 1 on A and 2 on B.
      wr(7'd1, 32'h0000_0010, 4'hF);
      wr(7'd2, 32'h0000_0020, 4'hF);
      wr(7'd3, 32'h0000_0030, 4'hF);
      drv(1'b0, 7'd0, 4'h0, 32'h0, 1'b1, 7'd1);
      tick();
      check("t3_n1_a_rv", 32'(if_a.rvalid), 32'd1);
      check("t3_n1_a_rd", if_a.rdata, 32'h0000_0010);
      check("t3_n1_b_rv", 32'(if_b.rvalid), 32'd0);
      drv(1'b0, 7'd0, 4'h0, 32'h0, 1'b1, 7'd2);
      tick();
      check("t3_n2_a_rd", if_a.rdata, 32'h0000_0020);
      check("t3_n2_b_rv", 32'(if_b.rvalid), 32'd1);
      check("t3_n2_b_rd", if_b.rdata, 32'h0000_0010);
      drv(1'b0, 7'd0, 4'h0, 32'h0, 1'b1, 7'd3);
      tick();
      check("t3_n3_a_rv", 32'(if_a.rvalid), 32'd1);
      check("t3_n3_a_rd", if_a.rdata, 32'h0000_0030);
      check("t3_n3_b_rd", if_b.rdata, 32'h0000_0020);
      idle();
      tick();
      check("t3_n4_a_rv", 32'(if_a.rvalid), 32'd0);
      check("t3_n4_a_hold", if_a.rdata, 32'h0000_0030);
      check("t3_n4_b_rv", 32'(if_b.rvalid), 32'd1);
      check("t3_n4_b_rd", if_b.rdata, 32'h0000_0030);
      tick();
      check("t3_n5_b_rv", 32'(if_b.rvalid), 32'd0);
      check("t3_n5_b_hold", if_b.rdata, 32'h0000_0030);

      // 4: same-address collision, full then partial byte enables.
      drv(1'b1, 7'd9, 4'b1111, 32'hDEAD_BEEF, 1'b1, 7'd9);
      tick();
      idle();
      check("t4_a_rv", 32'(if_a.rvalid), 32'd1);
      check("t4_a_old", if_a.rdata, 32'h0000_0000);
      tick();
      check("t4_b_rv", 32'(if_b.rvalid), 32'd1);
      check("t4_b_new", if_b.rdata, 32'hDEAD_BEEF);
      rd("t4_after", 7'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      drv(1'b1, 7'd9, 4'b0011, 32'h1234_5678, 1'b1, 7'd9);
      tick();
      idle();
      check("t4p_a_old", if_a.rdata, 32'hDEAD_BEEF);
      tick();
      check("t4p_b_merged", if_b.rdata, 32'hDEAD_5678);
      rd("t4p_after", 7'd9, 32'hDEAD_5678, 32'hDEAD_5678);

      // 5: port traffic during the sweep is ignored.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_sweep("t5_sweep", 128, 1'b1);
      rd("t5_addr3", 7'd3, 32'h0000_0000, 32'h0000_0000);

      // 6: reset with a read in flight, then reset again at sweep index 60.
      wr(7'd5, 32'h0000_0055, 4'hF);
      drv(1'b0, 7'd0, 4'h0, 32'h0, 1'b1, 7'd5);
      tick();
      idle();
      check("t6_a_rv", 32'(if_a.rvalid), 32'd1);
      check("t6_a_rd", if_a.rdata, 32'h0000_0055);
      rst = 1'b1;
      tick();
      check("t6_rst_a_rv", 32'(if_a.rvalid), 32'd0);
      check("t6_rst_b_rv", 32'(if_b.rvalid), 32'd0);
      check("t6_rst_a_rd", if_a.rdata, 32'h0000_0000);
      check("t6_rst_b_rd", if_b.rdata, 32'h0000_0000);
      rst = 1'b0;
      cnt = 0;
      seen_rv = 1'b0;
      while (cnt < 60) begin
         tick();
         cnt++;
         if (if_a.rvalid || if_b.rvalid) begin
            seen_rv = 1'b1;
         end
      end
      check("t6_no_stale_rv", 32'(seen_rv), 32'd0);
      check("t6_busy_at60", 32'(if_a.init_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_sweep("t6_sweep", 128, 1'b0);
      rd("t6_addr5", 7'd5, 32'h0000_0000, 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
